// File: rtl/alu_pkg.sv
// Shared types for the 4-bit CPU execute stage: opcode encoding, FSM states, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    // Opcodes C-F are unassigned and execute as NOP.
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_ADD  = 4'h2,
        OP_ADC  = 4'h3,
        OP_SUB  = 4'h4,
        OP_SBC  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_SHL  = 4'h9,
        OP_SHR  = 4'hA,
        OP_CLR  = 4'hB
    } alu_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/carry_ripple_adder.sv
// Purpose: plain ripple-carry adder, sum = a + b + carry_in.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module carry_ripple_adder #(
    parameter int CRA_BIT_NUMB = 4
) (
    input  logic [CRA_BIT_NUMB-1:0] a_i,
    input  logic [CRA_BIT_NUMB-1:0] b_i,
    input  logic                    carry_i,
    output logic [CRA_BIT_NUMB-1:0] sum_o,
    output logic                    carry_o
);

    logic carry;

    // Ripple the carry bit by bit from LSB to MSB.
    always_comb begin
        carry = carry_i;
        sum_o = '0;
        for (int i = 0; i < CRA_BIT_NUMB; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        carry_o = carry;
    end

endmodule

// File: rtl/alu_accumulator.sv
// Purpose: execute stage; accumulator ALU with C/Z (and optional V via ALU_ACC_OVERFLOW_FLAG_EN) flags.
// Latency: 1 cycle for most ops (done_o next cycle); SHL/SHR by n>0 retire after n extra cycles.
// Backpressure: ready_o low only while a multi-cycle shift runs; valid_i then is dropped, not queued.
module alu_accumulator
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  alu_op_e            op_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [WIDTH-1:0]   acc_o,
    output logic               carry_flag_o,
    output logic               zero_flag_o,
    output logic               done_o
`ifdef ALU_ACC_OVERFLOW_FLAG_EN
    ,
    output logic               overflow_flag_o
`endif
);

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   acc_q;
    logic               c_q;
    logic               done_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               shl_q;

    logic               accept;
    logic               long_shift;
    logic               shift_step;
    logic               last_step;

    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    assign accept     = valid_i & ready_o;
    assign long_shift = is_shift_op(op_i) && (shamt_i != '0);
    assign last_step  = (cnt_q == SHAMT_W'(1));

    // Adder always sees ACC as A; B and carry-in are chosen by the arithmetic opcode.
    always_comb begin
        add_b   = operand_i;
        add_cin = 1'b0;
        case (op_i)
            OP_ADC:  add_cin = c_q;
            OP_SUB: begin
                add_b   = ~operand_i;
                add_cin = 1'b1;
            end
            OP_SBC: begin
                add_b   = ~operand_i;
                add_cin = c_q;
            end
            default: ;
        endcase
    end

    carry_ripple_adder #(
        .CRA_BIT_NUMB (WIDTH)
    ) u_adder (
        .a_i     (acc_q),
        .b_i     (add_b),
        .carry_i (add_cin),
        .sum_o   (add_sum),
        .carry_o (add_cout)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: enter SHIFT on a nonzero shift, leave after the last step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && long_shift) state_d = SHIFT;
            SHIFT:   if (last_step)            state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: accept only in IDLE, step the shifter only in SHIFT.
    always_comb begin
        ready_o    = (state_q == IDLE);
        shift_step = (state_q == SHIFT);
    end

    // Accumulator, carry, shift counter and retire pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            c_q    <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            shl_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (shift_step) begin
                if (shl_q) begin
                    c_q   <= acc_q[WIDTH-1];
                    acc_q <= {acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    c_q   <= acc_q[0];
                    acc_q <= {1'b0, acc_q[WIDTH-1:1]};
                end
                cnt_q <= cnt_q - SHAMT_W'(1);
                if (last_step) done_q <= 1'b1;
            end else if (accept) begin
                done_q <= !long_shift;
                case (op_i)
                    OP_LOAD: acc_q <= operand_i;
                    OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                        acc_q <= add_sum;
                        c_q   <= add_cout;
                    end
                    OP_AND: begin
                        acc_q <= acc_q & operand_i;
                        c_q   <= 1'b0;
                    end
                    OP_OR: begin
                        acc_q <= acc_q | operand_i;
                        c_q   <= 1'b0;
                    end
                    OP_XOR: begin
                        acc_q <= acc_q ^ operand_i;
                        c_q   <= 1'b0;
                    end
                    OP_SHL, OP_SHR: begin
                        cnt_q <= shamt_i;
                        shl_q <= (op_i == OP_SHL);
                    end
                    OP_CLR:  acc_q <= '0;
                    default: ;
                endcase
            end
        end
    end

`ifdef ALU_ACC_OVERFLOW_FLAG_EN
    logic v_q;

    // Signed overflow on arithmetic; logic ops and shifts clear it, others keep it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q <= 1'b0;
        end else if (accept) begin
            case (op_i)
                OP_ADD, OP_ADC, OP_SUB, OP_SBC:
                    v_q <= (acc_q[WIDTH-1] == add_b[WIDTH-1]) &&
                           (add_sum[WIDTH-1] != acc_q[WIDTH-1]);
                OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR:
                    v_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign overflow_flag_o = v_q;
`endif

    // Z always mirrors the accumulator, so it tracks every ACC write including shift steps.
    assign acc_o        = acc_q;
    assign carry_flag_o = c_q;
    assign zero_flag_o  = (acc_q == '0);
    assign done_o       = done_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Randomized and directed bench for alu_accumulator against an arithmetic reference model.
// Latency: checks done_o one cycle after accept, or after n shift cycles.
// Backpressure: drives junk valid_i while ready_o is low and expects it dropped.
module tb_alu_accumulator;
    import alu_pkg::*;

    localparam int W = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    alu_op_e      op_i;
    logic [W-1:0] operand_i;
    logic [1:0]   shamt_i;
    logic [W-1:0] acc_o;
    logic         carry_flag_o;
    logic         zero_flag_o;
    logic         done_o;
`ifdef ALU_ACC_OVERFLOW_FLAG_EN
    logic         overflow_flag_o;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state.
    int m_acc;
    int m_c;
    int m_v;

    alu_accumulator #(.WIDTH(W), .SHAMT_W(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .op_i         (op_i),
        .operand_i    (operand_i),
        .shamt_i      (shamt_i),
        .acc_o        (acc_o),
        .carry_flag_o (carry_flag_o),
        .zero_flag_o  (zero_flag_o),
        .done_o       (done_o)
`ifdef ALU_ACC_OVERFLOW_FLAG_EN
        ,
        .overflow_flag_o (overflow_flag_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int to_signed(input int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    // Architectural effect of one op on the model, computed with whole-word arithmetic.
    task automatic model_apply(input int op, input int opnd, input int sh);
        int bval, cin, tmp, s;
        case (op)
            1: m_acc = opnd;
            2, 3, 4, 5: begin
                bval = (op >= 4) ? ((~opnd) & 15) : opnd;
                cin  = (op == 2) ? 0 : (op == 4) ? 1 : m_c;
                tmp  = m_acc + bval + cin;
                s    = to_signed(m_acc) + to_signed(bval) + cin;
                m_v  = (s > 7 || s < -8) ? 1 : 0;
                m_acc = tmp % 16;
                m_c   = tmp / 16;
            end
            6: begin m_acc = m_acc & opnd; m_c = 0; m_v = 0; end
            7: begin m_acc = m_acc | opnd; m_c = 0; m_v = 0; end
            8: begin m_acc = m_acc ^ opnd; m_c = 0; m_v = 0; end
            9: begin
                if (sh > 0) begin
                    m_c   = (m_acc >> (W - sh)) & 1;
                    m_acc = (m_acc << sh) % 16;
                end
                m_v = 0;
            end
            10: begin
                if (sh > 0) begin
                    m_c   = (m_acc >> (sh - 1)) & 1;
                    m_acc = m_acc >> sh;
                end
                m_v = 0;
            end
            11: m_acc = 0;
            default: ;
        endcase
    endtask

    task automatic check_arch(input string tag);
        check_val({tag, "_acc"}, acc_o, m_acc);
        check_val({tag, "_c"}, carry_flag_o, m_c);
        check_val({tag, "_z"}, zero_flag_o, (m_acc == 0) ? 1 : 0);
`ifdef ALU_ACC_OVERFLOW_FLAG_EN
        check_val({tag, "_v"}, overflow_flag_o, m_v);
`endif
    endtask

    // Issue one op starting just before a rising edge and check it at retirement.
    task automatic run_op(input int op, input int opnd, input int sh);
        bit long_sh;
        long_sh = (op == 9 || op == 10) && (sh != 0);
        check_val("ready_pre", ready_o, 1);
        valid_i   = 1'b1;
        op_i      = alu_op_e'(4'(op));
        operand_i = 4'(opnd);
        shamt_i   = 2'(sh);
        model_apply(op, opnd, sh);
        @(posedge clk_i); #1;
        if (long_sh) begin
            for (int i = 0; i < sh; i++) begin
                valid_i   = 1'b1;
                op_i      = alu_op_e'(4'($urandom_range(0, 15)));
                operand_i = 4'($urandom_range(0, 15));
                @(negedge clk_i);
                check_val("shift_ready", ready_o, 0);
                check_val("shift_done", done_o, 0);
                @(posedge clk_i); #1;
            end
        end
        valid_i = 1'b0;
        @(negedge clk_i);
        check_val("done", done_o, 1);
        check_val("ready_post", ready_o, 1);
        check_arch("op");
    endtask

    task automatic idle_cycle();
        valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check_val("idle_done", done_o, 0);
        check_arch("idle");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; op_i = OP_NOP; operand_i = '0; shamt_i = '0;
        m_acc = 0; m_c = 0; m_v = 0;
        @(negedge clk_i); @(negedge clk_i);
        check_val("rst_ready", ready_o, 1);
        check_val("rst_done", done_o, 0);
        check_arch("rst");
        rst_i = 1'b0;

        // LOAD F, ADD 1 wraps to 0 with carry; ADC 0 consumes the carry.
        run_op(1, 15, 0);
        run_op(2, 1, 0);
        check_val("add_wrap_acc", acc_o, 0);
        check_val("add_wrap_c", carry_flag_o, 1);
        idle_cycle();
        run_op(3, 0, 0);
        check_val("adc_acc", acc_o, 1);
        check_val("adc_z", zero_flag_o, 0);

        // Subtraction: C=1 means no borrow.
        run_op(1, 5, 0);
        run_op(4, 5, 0);
        check_val("sub_eq_c", carry_flag_o, 1);
        run_op(4, 1, 0);
        check_val("sub_borrow_acc", acc_o, 15);
        check_val("sub_borrow_c", carry_flag_o, 0);

        // Multi-cycle shift, then zero-amount shift and AND.
        run_op(1, 9, 0);
        run_op(9, 0, 2);
        check_val("shl2_acc", acc_o, 4);
        check_val("shl2_c", carry_flag_o, 0);
        run_op(1, 9, 0);
        run_op(10, 0, 0);
        check_val("shr0_acc", acc_o, 9);
        run_op(6, 0, 0);
        check_val("and0_z", zero_flag_o, 1);

        // Signed overflow case (model drives V expectation when the flag is built in).
        run_op(1, 7, 0);
        run_op(2, 1, 0);
        check_val("ovf_acc", acc_o, 8);
        check_val("ovf_c", carry_flag_o, 0);
        run_op(12, 3, 0);
        idle_cycle();

        // Reset in the middle of a shift aborts it.
        run_op(1, 9, 0);
        valid_i = 1'b1; op_i = OP_SHL; operand_i = '0; shamt_i = 2'd3;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        check_val("mid_ready", ready_o, 0);
        #2 rst_i = 1'b1;
        #1;
        m_acc = 0; m_c = 0; m_v = 0;
        check_val("abort_ready", ready_o, 1);
        check_val("abort_done", done_o, 0);
        check_arch("abort");
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_cycle();

        // Random op stream.
        for (int k = 0; k < 300; k++) begin
            run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
